ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; sits between ID (producer of id_to_ex_bus) and MEM.
- Registers the ID bundle, selects operands, and runs the ALU.
- Issues the data SRAM request, forwards its result to ID over ex_to_id_bus, and owns HI/LO.
- Contains an iterative 32-cycle divider for DIV/DIVU; stalls the pipe through stallreq_for_ex while a divide runs.

---
 rtl/ex_stage_pkg.sv | 73 +++++++
 rtl/div_iter.sv | 130 +++++++++++++
 rtl/ex_stage.sv | 151 +++++++++++++++
 tb/tb_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// ex_stage_pkg
// Shared defines for the execute stage: bus widths, stall-vector encoding,
// divider state encoding, SPECIAL function codes and the ID/EX bundle layout.
// Revision: 1.0
// ============================================================================
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int STALLBUS_WD  = 6;
    localparam int DIV_CYCLES   = 32;

    // Stall vector bit positions and polarity
    localparam int   STALL_ID_EX  = 2;
    localparam int   STALL_EX_MEM = 3;
    localparam logic STOP         = 1'b1;
    localparam logic NO_STOP      = 1'b0;

    // Divider sequencing
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // SPECIAL (opcode 0) function codes decoded in EX
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    // One-hot ALU operation bit positions (add is the MSB)
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    // Layout of the bundle handed over by ID (MSB first)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// div_iter
// Iterative restoring divider, one quotient bit per BUSY cycle. Works on
// operand magnitudes and fixes signs on the way out; divide-by-zero yields
// an all-ones quotient and returns the dividend as remainder.
// Revision: 1.0
// ============================================================================
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int               CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic             load;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dsr_q;
    logic             neg_quo;
    logic             neg_rem;
    logic             dsr_zero;

    logic [31:0]      dvd_mag;
    logic [31:0]      dsr_mag;
    logic [32:0]      trial;
    logic [32:0]      diff;
    logic             take;
    logic [31:0]      step_rem;

    assign dvd_mag = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign dsr_mag = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

    // Shift the next dividend bit into the partial remainder and try a subtract;
    // a clear borrow bit means the divisor fits.
    assign trial    = {rem_q, quo_q[31]};
    assign diff     = trial - {1'b0, dsr_q};
    assign take     = ~diff[32];
    assign step_rem = take ? diff[31:0] : trial[31:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; busy rises in IDLE as soon as start
    // is seen so the pipe freezes before the operands are captured.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    load       = 1'b1;
                    state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // Always return to IDLE: the divide instruction is still in EX
                // this cycle and must not start a second division.
                done       = 1'b1;
                state_next = DIV_IDLE;
            end
            default: begin
                state_next = DIV_IDLE;
            end
        endcase
    end

    // Operand capture and one restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            dsr_zero <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= dvd_mag;
            dsr_q    <= dsr_mag;
            neg_quo  <= is_signed & (dividend[31] ^ divisor[31]);
            neg_rem  <= is_signed & dividend[31];
            dsr_zero <= (divisor == 32'd0);
        end else if (state == DIV_BUSY) begin
            cnt   <= cnt + 1'b1;
            rem_q <= step_rem;
            quo_q <= {quo_q[30:0], take};
        end
    end

    // Sign correction; a zero divisor leaves the all-ones quotient untouched
    // while the remainder path already reproduces the dividend.
    assign quotient  = dsr_zero ? 32'hFFFF_FFFF : (neg_quo ? (32'd0 - quo_q) : quo_q);
    assign remainder = neg_rem ? (32'd0 - rem_q) : rem_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage
// Execute stage of the 5-stage MIPS pipe: ID/EX register, operand select,
// one-hot ALU, data SRAM request, forwarding to ID, HI/LO ownership and the
// iterative divider that stalls the pipe while it runs.
// Revision: 1.0
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALLBUS_WD-1:0]   stall,
    output logic                     stallreq_for_ex,
    input  logic [ID_TO_EX_WD-1:0]   id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0]  ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]   ex_to_id_bus,
    output logic                     data_sram_en,
    output logic [3:0]               data_sram_wen,
    output logic [31:0]              data_sram_addr,
    output logic [31:0]              data_sram_wdata
);

    id_ex_t      id_ex;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [4:0]  shamt;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    logic [31:0] ex_result;

    logic        is_special;
    logic        inst_div;
    logic        inst_divu;
    logic        inst_mfhi;
    logic        inst_mflo;
    logic        inst_mthi;
    logic        inst_mtlo;

    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // ID/EX pipeline register: bubble when EX stalls but MEM moves on
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex <= '0;
        end else if (stall[STALL_ID_EX] == STOP && stall[STALL_EX_MEM] == NO_STOP) begin
            id_ex <= '0;
        end else if (stall[STALL_ID_EX] == NO_STOP) begin
            id_ex <= id_ex_t'(id_to_ex_bus);
        end
    end

    // Decode of the SPECIAL instructions handled in EX
    assign is_special = (id_ex.inst[31:26] == OP_SPECIAL);
    assign inst_div   = is_special && (id_ex.inst[5:0] == FUNC_DIV);
    assign inst_divu  = is_special && (id_ex.inst[5:0] == FUNC_DIVU);
    assign inst_mfhi  = is_special && (id_ex.inst[5:0] == FUNC_MFHI);
    assign inst_mflo  = is_special && (id_ex.inst[5:0] == FUNC_MFLO);
    assign inst_mthi  = is_special && (id_ex.inst[5:0] == FUNC_MTHI);
    assign inst_mtlo  = is_special && (id_ex.inst[5:0] == FUNC_MTLO);

    // Operand selection (one-hot selects)
    assign imm_sext = sign_ext16(id_ex.inst[15:0]);
    assign imm_zext = {16'd0, id_ex.inst[15:0]};

    assign src1 = ({32{id_ex.sel_alu_src1[0]}} & id_ex.rdata1)
                | ({32{id_ex.sel_alu_src1[1]}} & id_ex.pc)
                | ({32{id_ex.sel_alu_src1[2]}} & {27'd0, id_ex.inst[10:6]});

    assign src2 = ({32{id_ex.sel_alu_src2[0]}} & id_ex.rdata2)
                | ({32{id_ex.sel_alu_src2[1]}} & imm_sext)
                | ({32{id_ex.sel_alu_src2[2]}} & 32'd8)
                | ({32{id_ex.sel_alu_src2[3]}} & imm_zext);

    assign shamt = src1[4:0];

    // One-hot ALU: each enabled operation ORs its result in
    always_comb begin
        alu_result = 32'd0;
        if (id_ex.alu_op[ALU_ADD])  alu_result = alu_result | (src1 + src2);
        if (id_ex.alu_op[ALU_SUB])  alu_result = alu_result | (src1 - src2);
        if (id_ex.alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, ($signed(src1) < $signed(src2))};
        if (id_ex.alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, (src1 < src2)};
        if (id_ex.alu_op[ALU_AND])  alu_result = alu_result | (src1 & src2);
        if (id_ex.alu_op[ALU_NOR])  alu_result = alu_result | ~(src1 | src2);
        if (id_ex.alu_op[ALU_OR])   alu_result = alu_result | (src1 | src2);
        if (id_ex.alu_op[ALU_XOR])  alu_result = alu_result | (src1 ^ src2);
        if (id_ex.alu_op[ALU_SLL])  alu_result = alu_result | (src2 << shamt);
        if (id_ex.alu_op[ALU_SRL])  alu_result = alu_result | (src2 >> shamt);
        if (id_ex.alu_op[ALU_SRA])  alu_result = alu_result | 32'($signed(src2) >>> shamt);
        if (id_ex.alu_op[ALU_LUI])  alu_result = alu_result | {src2[15:0], 16'd0};
    end

    // HI/LO reads see the currently registered values
    assign ex_result = inst_mfhi ? hi : (inst_mflo ? lo : alu_result);

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (inst_div | inst_divu),
        .is_signed (inst_div),
        .dividend  (id_ex.rdata1),
        .divisor   (id_ex.rdata2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign stallreq_for_ex = div_busy;

    // HI/LO: divide results on completion, MTHI/MTLO only when EX advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
        end else if (stall[STALL_EX_MEM] == NO_STOP) begin
            if (inst_mthi) hi <= id_ex.rdata1;
            if (inst_mtlo) lo <= id_ex.rdata1;
        end
    end

    assign data_sram_en    = id_ex.data_ram_en;
    assign data_sram_wen   = id_ex.data_ram_wen;
    assign data_sram_addr  = id_ex.rdata1 + imm_sext;
    assign data_sram_wdata = id_ex.rdata2;

    assign ex_to_mem_bus = {id_ex.pc, id_ex.data_ram_en, id_ex.data_ram_wen,
                            id_ex.sel_rf_res, id_ex.rf_we, id_ex.rf_waddr, ex_result};

    assign ex_to_id_bus  = {id_ex.rf_we, id_ex.rf_waddr, ex_result};

    // Stall lanes owned by other stages and the rs/rt fields are not used here
    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], id_ex.inst[25:16]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage
// Directed self-checking bench for ex_stage with hand-computed expectations.
// Revision: 1.0
// ============================================================================
module tb_ex_stage;

    localparam logic [11:0] A_ADD  = 12'h800;
    localparam logic [11:0] A_SUB  = 12'h400;
    localparam logic [11:0] A_SLT  = 12'h200;
    localparam logic [11:0] A_SLTU = 12'h100;
    localparam logic [11:0] A_NOR  = 12'h040;
    localparam logic [11:0] A_XOR  = 12'h010;
    localparam logic [11:0] A_SRL  = 12'h004;
    localparam logic [11:0] A_SRA  = 12'h002;
    localparam logic [11:0] A_LUI  = 12'h001;
    localparam logic [31:0] PC0    = 32'hBFC0_0000;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic         stallreq_for_ex;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    logic         ovr_en;
    logic [5:0]   ovr_stall;

    int n_checks;
    int n_pass;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .stallreq_for_ex (stallreq_for_ex),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    // Stall controller model: an EX stall request freezes stages 0..3
    assign stall = ovr_en ? ovr_stall : (stallreq_for_ex ? 6'b001111 : 6'b000000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [158:0] mk(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic en, input logic [3:0] wen,
        input logic we, input logic [4:0] wa, input logic srf,
        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, srf, r1, r2};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] func);
        return {6'b000000, 5'd4, 5'd5, 5'd3, sa, func};
    endfunction

    // Present a bundle and let it enter EX
    task automatic issue(input logic [158:0] b);
        id_to_ex_bus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(input string tag, input logic [158:0] b, input logic [31:0] exp);
        issue(b);
        check(tag, ex_to_id_bus[31:0], exp);
    endtask

    // Run a divide, count stall cycles, then read LO and HI back
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] qexp, input logic [31:0] rexp);
        int n;
        issue(mk(PC0, rtype(5'd0, sgn ? 6'b011010 : 6'b011011), 12'h000,
                 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
        id_to_ex_bus = mk(PC0 + 4, rtype(5'd0, 6'b010010), 12'h000,
                          3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0);
        n = 0;
        while (stallreq_for_ex === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " stall cycles"}, 76'(n), 76'd33);
        @(posedge clk);
        #1;
        check({tag, " mflo"}, ex_to_id_bus, {1'b1, 5'd3, qexp});
        issue(mk(PC0 + 8, rtype(5'd0, 6'b010000), 12'h000,
                 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0));
        check({tag, " mfhi"}, ex_to_id_bus, {1'b1, 5'd2, rexp});
    endtask

    logic [159:0] rnd;
    logic [158:0] sw_b;
    int           n;

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b0;
        ovr_en       = 1'b1;
        ovr_stall    = 6'b0;
        id_to_ex_bus = '0;

        // Reset held with random inputs: everything stays zero
        for (int i = 0; i < 3; i++) begin
            rnd          = {$urandom, $urandom, $urandom, $urandom, $urandom};
            id_to_ex_bus = rnd[158:0];
            ovr_stall    = 6'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst ex_to_mem", ex_to_mem_bus, 76'd0);
        check("rst ex_to_id", ex_to_id_bus, 76'd0);
        check("rst stallreq", stallreq_for_ex, 76'd0);
        check("rst sram_en/wen", {data_sram_en, data_sram_wen}, 76'd0);
        check("rst sram_addr", data_sram_addr, 76'd0);
        check("rst sram_wdata", data_sram_wdata, 76'd0);

        // Release and push ADDU overflow case
        ovr_en = 1'b0;
        rst    = 1'b1;
        issue(mk(PC0, rtype(5'd0, 6'b100001), A_ADD, 3'b001, 4'b0001,
                 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001));
        check("addu fwd", ex_to_id_bus, {1'b1, 5'd5, 32'h8000_0000});
        check("addu mem bus", ex_to_mem_bus,
              {PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h8000_0000});

        // Store word with negative offset
        sw_b = mk(PC0 + 4, {6'b101011, 5'd4, 5'd5, 16'hFFFC}, A_ADD, 3'b001, 4'b0010,
                  1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
        issue(sw_b);
        check("sw addr", data_sram_addr, 32'h0000_0FFC);
        check("sw wdata", data_sram_wdata, 32'hDEAD_BEEF);
        check("sw en/wen", {data_sram_en, data_sram_wen}, 5'b11111);
        check("sw result", ex_to_id_bus[31:0], 32'h0000_0FFC);

        // ALU patterns
        alu_chk("sub", mk(PC0, rtype(5'd0, 6'b100011), A_SUB, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd5, 32'd7), 32'hFFFF_FFFE);
        alu_chk("slt", mk(PC0, rtype(5'd0, 6'b101010), A_SLT, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd1);
        alu_chk("sltu", mk(PC0, rtype(5'd0, 6'b101011), A_SLTU, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'hFFFF_FFFF, 32'd1), 32'd0);
        alu_chk("nor", mk(PC0, rtype(5'd0, 6'b100111), A_NOR, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000), 32'h0000_0F0F);
        alu_chk("sra", mk(PC0, rtype(5'd4, 6'b000011), A_SRA, 3'b100, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd0, 32'h8000_0000), 32'hF800_0000);
        alu_chk("srl", mk(PC0, rtype(5'd4, 6'b000010), A_SRL, 3'b100, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd0, 32'h8000_0000), 32'h0800_0000);
        alu_chk("lui", mk(PC0, {6'b001111, 5'd0, 5'd8, 16'h1234}, A_LUI, 3'b000, 4'b1000,
                1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd0, 32'd0), 32'h1234_0000);
        alu_chk("xori zext", mk(PC0, {6'b001110, 5'd4, 5'd8, 16'h8001}, A_XOR, 3'b001, 4'b1000,
                1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'h0000_FFFF, 32'd0), 32'h0000_7FFE);
        alu_chk("pc+8", mk(PC0 + 32'h100, {6'b000011, 26'd0}, A_ADD, 3'b010, 4'b0100,
                1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0), 32'hBFC0_0108);

        // Divides
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("divu 9/0", 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        do_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);

        // MTHI/MTLO followed immediately by the matching read
        issue(mk(PC0, rtype(5'd0, 6'b010001), 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0000_1234, 32'd0));
        alu_chk("mthi->mfhi", mk(PC0, rtype(5'd0, 6'b010000), 12'h000, 3'b000, 4'b0000,
                1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0), 32'h0000_1234);
        issue(mk(PC0, rtype(5'd0, 6'b010011), 12'h000, 3'b000, 4'b0000,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0000_5678, 32'd0));
        alu_chk("mtlo->mflo", mk(PC0, rtype(5'd0, 6'b010010), 12'h000, 3'b000, 4'b0000,
                1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0), 32'h0000_5678);

        // Hold then bubble
        issue(sw_b);
        ovr_en    = 1'b1;
        ovr_stall = 6'b001100;
        issue(mk(PC0, rtype(5'd0, 6'b100001), A_ADD, 3'b001, 4'b0001,
                 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd1, 32'd1));
        check("hold mem bus", ex_to_mem_bus,
              {PC0 + 32'd4, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0FFC});
        ovr_stall = 6'b000100;
        @(posedge clk);
        #1;
        check("bubble rf_we/en", {ex_to_mem_bus[37], data_sram_en}, 76'd0);
        check("bubble mem bus", ex_to_mem_bus, 76'd0);
        ovr_en = 1'b0;

        // Reset in the middle of a divide (BUSY count 10)
        issue(mk(PC0, rtype(5'd0, 6'b011010), 12'h000, 3'b001, 4'b0001,
                 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd3));
        id_to_ex_bus = mk(PC0 + 4, rtype(5'd0, 6'b010000), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0);
        n = 0;
        while (stallreq_for_ex === 1'b1 && n < 11) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("busy before abort", {stallreq_for_ex, 8'(n)}, {1'b1, 8'd11});
        rst = 1'b0;
        #1;
        check("abort stallreq", stallreq_for_ex, 76'd0);
        check("abort mem bus", ex_to_mem_bus, 76'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort hi", ex_to_id_bus, {1'b1, 5'd2, 32'd0});
        alu_chk("abort lo", mk(PC0, rtype(5'd0, 6'b010010), 12'h000, 3'b000, 4'b0000,
                1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0), 32'd0);
        check("idle stallreq", stallreq_for_ex, 76'd0);
        do_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
